vector_writeback_stage: RTL and testbench

Result writeback stage directly downstream of the registered vector logic unit and the other vector execution units. It takes a whole-register result `vd`, the old destination contents and the `v0` mask, and applies RVV mask and tail policy per element for the current SEW/vl. It buffers the merged register in a 2-entry FIFO and presents it to the vector register file write port with a valid/ready handshake. It also exports a pending-destination scoreboard so issue logic can stall RAW hazards.

---
 rtl/vector_writeback_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_vector_writeback_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vector_writeback_stage.sv
// -----------------------------------------------------------------------------
// vector_writeback_stage
//
// Purpose:
//   Final stage before the vector register file write port. A whole-register
//   result is merged per element with the old destination contents, following
//   RVV mask (vm/v0/vma) and tail (vl/vta) policy for the current SEW. The
//   merged word is queued in a 2-entry in-order FIFO and retired through a
//   valid/ready write port. A registered pending-destination mask lets issue
//   logic stall RAW hazards on registers that still have writes in flight.
//
// Ports:
//   clock, reset_n          rising-edge clock, async active-low reset
//   in_valid / in_ready     result handshake (in_ready depends on state only)
//   in_vd_addr              destination register index
//   in_result, in_old_vd    raw unit result and current destination contents
//   in_v0, in_vm            mask register and unmasked-op flag
//   in_vsew, in_vl          element width code and active element count
//   in_vta, in_vma          tail / mask agnostic policy (agnostic = all ones)
//   wb_valid / wb_ready     VRF write handshake
//   wb_addr, wb_data        head FIFO entry
//   pending_mask            one bit per vr with a queued write
//   illegal_sew             sticky flag: reserved vsew was accepted
//   wb_count                retired writes, wraps modulo 2^32
// -----------------------------------------------------------------------------
module vector_writeback_stage #(
  parameter int VLEN  = 128,
  parameter int DEPTH = 2
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [4:0]                  in_vd_addr,
  input  logic [VLEN-1:0]             in_result,
  input  logic [VLEN-1:0]             in_old_vd,
  input  logic [VLEN-1:0]             in_v0,
  input  logic                        in_vm,
  input  logic [2:0]                  in_vsew,
  input  logic [$clog2(VLEN/8):0]     in_vl,
  input  logic                        in_vta,
  input  logic                        in_vma,
  output logic                        wb_valid,
  input  logic                        wb_ready,
  output logic [4:0]                  wb_addr,
  output logic [VLEN-1:0]             wb_data,
  output logic [31:0]                 pending_mask,
  output logic                        illegal_sew,
  output logic [31:0]                 wb_count
);

  localparam int NB   = VLEN / 8;           // bytes per register
  localparam int VL_W = $clog2(NB) + 1;     // width of in_vl
  localparam int IX_W = $clog2(VLEN);       // wide enough to index any v0 bit

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  occ_e               occ_r;
  logic               wr_ptr_r;
  logic               rd_ptr_r;
  logic [DEPTH-1:0]   ent_valid_r;
  logic [4:0]         ent_addr_r [DEPTH];
  logic [VLEN-1:0]    ent_data_r [DEPTH];
  logic [31:0]        pending_r;
  logic [31:0]        count_r;
  logic               illegal_r;

  logic               accept_s;
  logic               drain_s;
  logic [VLEN-1:0]    merged_s;
  logic [DEPTH-1:0]   ent_valid_nxt_s;
  logic [4:0]         ent_addr_nxt_s [DEPTH];
  logic [31:0]        pending_nxt_s;

  // Per-element mask/tail merge. Every byte of an element shares that
  // element's policy, so the merge is done byte by byte using the byte's
  // element index (byte >> log2(SEW/8)). Reserved vsew passes result through.
  function automatic logic [VLEN-1:0] merge_fn(
    input logic [VLEN-1:0] result,
    input logic [VLEN-1:0] old_vd,
    input logic [VLEN-1:0] v0,
    input logic            vm,
    input logic [2:0]      vsew,
    input logic [VL_W-1:0] vl,
    input logic            vta,
    input logic            vma
  );
    logic [VLEN-1:0] out_v;
    logic [IX_W-1:0] vlmax;
    logic [IX_W-1:0] vl_eff;
    logic [IX_W-1:0] idx;
    logic [1:0]      sh;
    out_v  = result;
    sh     = vsew[1:0];
    vlmax  = IX_W'(NB) >> sh;
    vl_eff = (IX_W'(vl) > vlmax) ? vlmax : IX_W'(vl);
    if (!vsew[2]) begin
      for (int b = 0; b < NB; b++) begin
        idx = IX_W'(b) >> sh;
        if (idx < vl_eff) begin
          if (vm || v0[idx]) begin
            out_v[b*8 +: 8] = result[b*8 +: 8];
          end else if (vma) begin
            out_v[b*8 +: 8] = 8'hFF;
          end else begin
            out_v[b*8 +: 8] = old_vd[b*8 +: 8];
          end
        end else if (vta) begin
          out_v[b*8 +: 8] = 8'hFF;
        end else begin
          out_v[b*8 +: 8] = old_vd[b*8 +: 8];
        end
      end
    end else begin
      out_v = result;
    end
    return out_v;
  endfunction

  assign accept_s = in_valid && (occ_r != OCC_FULL);
  assign drain_s  = (occ_r != OCC_EMPTY) && wb_ready;
  assign merged_s = merge_fn(in_result, in_old_vd, in_v0, in_vm, in_vsew,
                             in_vl, in_vta, in_vma);

  assign in_ready     = (occ_r != OCC_FULL);
  assign wb_valid     = (occ_r != OCC_EMPTY);
  assign wb_addr      = ent_addr_r[rd_ptr_r];
  assign wb_data      = ent_data_r[rd_ptr_r];
  assign pending_mask = pending_r;
  assign illegal_sew  = illegal_r;
  assign wb_count     = count_r;

  // Next per-entry valid/address and the pending mask derived from them, so
  // the registered mask reflects the FIFO contents right after each edge.
  // Accept and drain never target the same slot in the same cycle.
  always_comb begin
    pending_nxt_s   = 32'd0;
    ent_valid_nxt_s = ent_valid_r;
    for (int j = 0; j < DEPTH; j++) begin
      ent_addr_nxt_s[j] = ent_addr_r[j];
      if (accept_s && (wr_ptr_r == 1'(j))) begin
        ent_valid_nxt_s[j] = 1'b1;
        ent_addr_nxt_s[j]  = in_vd_addr;
      end else if (drain_s && (rd_ptr_r == 1'(j))) begin
        ent_valid_nxt_s[j] = 1'b0;
      end else begin
        ent_valid_nxt_s[j] = ent_valid_r[j];
      end
      pending_nxt_s = pending_nxt_s |
                      ({32{ent_valid_nxt_s[j]}} & (32'd1 << ent_addr_nxt_s[j]));
    end
  end

  // Occupancy FSM and FIFO pointers (pointers wrap modulo 2).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      occ_r    <= OCC_EMPTY;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
    end else begin
      case (occ_r)
        OCC_EMPTY: begin
          if (accept_s) occ_r <= OCC_ONE;
          else          occ_r <= OCC_EMPTY;
        end
        OCC_ONE: begin
          if (accept_s && !drain_s)      occ_r <= OCC_FULL;
          else if (!accept_s && drain_s) occ_r <= OCC_EMPTY;
          else                           occ_r <= OCC_ONE;
        end
        OCC_FULL: begin
          if (drain_s) occ_r <= OCC_ONE;
          else         occ_r <= OCC_FULL;
        end
        default: occ_r <= OCC_EMPTY;
      endcase
      wr_ptr_r <= accept_s ? ~wr_ptr_r : wr_ptr_r;
      rd_ptr_r <= drain_s  ? ~rd_ptr_r : rd_ptr_r;
    end
  end

  // FIFO storage: merged word, address and slot-valid per entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ent_valid_r <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        ent_addr_r[j] <= 5'd0;
        ent_data_r[j] <= '0;
      end
    end else begin
      ent_valid_r <= ent_valid_nxt_s;
      for (int j = 0; j < DEPTH; j++) begin
        ent_addr_r[j] <= ent_addr_nxt_s[j];
        if (accept_s && (wr_ptr_r == 1'(j))) begin
          ent_data_r[j] <= merged_s;
        end else begin
          ent_data_r[j] <= ent_data_r[j];
        end
      end
    end
  end

  // Status registers: pending mask, sticky reserved-SEW flag, retire count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_r <= 32'd0;
      illegal_r <= 1'b0;
      count_r   <= 32'd0;
    end else begin
      pending_r <= pending_nxt_s;
      illegal_r <= illegal_r | (accept_s & in_vsew[2]);
      count_r   <= drain_s ? (count_r + 32'd1) : count_r;
    end
  end

endmodule

// File: tb/tb_vector_writeback_stage.sv
module tb_vector_writeback_stage;

  localparam int VLEN = 128;
  localparam int VL_W = $clog2(VLEN/8) + 1;

  logic              clock;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_vd_addr;
  logic [VLEN-1:0]   in_result;
  logic [VLEN-1:0]   in_old_vd;
  logic [VLEN-1:0]   in_v0;
  logic              in_vm;
  logic [2:0]        in_vsew;
  logic [VL_W-1:0]   in_vl;
  logic              in_vta;
  logic              in_vma;
  logic              wb_valid;
  logic              wb_ready;
  logic [4:0]        wb_addr;
  logic [VLEN-1:0]   wb_data;
  logic [31:0]       pending_mask;
  logic              illegal_sew;
  logic [31:0]       wb_count;

  vector_writeback_stage #(.VLEN(VLEN), .DEPTH(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_vd_addr(in_vd_addr),
    .in_result(in_result), .in_old_vd(in_old_vd), .in_v0(in_v0),
    .in_vm(in_vm), .in_vsew(in_vsew), .in_vl(in_vl),
    .in_vta(in_vta), .in_vma(in_vma),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
    .wb_data(wb_data), .pending_mask(pending_mask),
    .illegal_sew(illegal_sew), .wb_count(wb_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]      addr;
    logic [VLEN-1:0] data;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_count;
  logic        m_illegal;
  int          n_cmp;
  int          n_mis;

  task automatic check_eq(input string tag, input logic [VLEN-1:0] obs,
                          input logic [VLEN-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Element-level reference merge written straight from the RVV rules.
  function automatic logic [VLEN-1:0] ref_merge(
    input logic [VLEN-1:0] res, input logic [VLEN-1:0] old,
    input logic [VLEN-1:0] v0, input logic vm, input logic [2:0] vsew,
    input logic [VL_W-1:0] vl, input logic vta, input logic vma);
    logic [VLEN-1:0] r;
    int sew, vlmax, vle, e;
    if (vsew[2]) return res;
    sew   = 8 << vsew[1:0];
    vlmax = VLEN / sew;
    vle   = (int'(vl) < vlmax) ? int'(vl) : vlmax;
    for (int i = 0; i < VLEN; i++) begin
      e = i / sew;
      if (e < vle) r[i] = (vm || v0[e]) ? res[i] : (vma ? 1'b1 : old[i]);
      else         r[i] = vta ? 1'b1 : old[i];
    end
    return r;
  endfunction

  task automatic check_outputs();
    logic [31:0] pm;
    pm = 32'd0;
    foreach (q[i]) pm = pm | (32'd1 << q[i].addr);
    check_eq("in_ready", VLEN'(in_ready), VLEN'(q.size() < 2));
    check_eq("wb_valid", VLEN'(wb_valid), VLEN'(q.size() > 0));
    if (q.size() > 0) begin
      check_eq("wb_addr", VLEN'(wb_addr), VLEN'(q[0].addr));
      check_eq("wb_data", wb_data, q[0].data);
    end
    check_eq("pending_mask", VLEN'(pending_mask), VLEN'(pm));
    check_eq("illegal_sew", VLEN'(illegal_sew), VLEN'(m_illegal));
    check_eq("wb_count", VLEN'(wb_count), VLEN'(m_count));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, check.
  task automatic cycle(input logic valid, input logic [4:0] addr,
                       input logic [VLEN-1:0] res, input logic [VLEN-1:0] old,
                       input logic [VLEN-1:0] v0, input logic vm,
                       input logic [2:0] vsew, input logic [VL_W-1:0] vl,
                       input logic vta, input logic vma, input logic wbr);
    bit acc, drn;
    ent_t e;
    in_valid = valid; in_vd_addr = addr; in_result = res; in_old_vd = old;
    in_v0 = v0; in_vm = vm; in_vsew = vsew; in_vl = vl;
    in_vta = vta; in_vma = vma; wb_ready = wbr;
    acc = valid && (q.size() < 2);
    drn = (q.size() > 0) && wbr;
    if (drn) begin
      void'(q.pop_front());
      m_count = m_count + 32'd1;
    end
    if (acc) begin
      e.addr = addr;
      e.data = ref_merge(res, old, v0, vm, vsew, vl, vta, vma);
      q.push_back(e);
      if (vsew[2]) m_illegal = 1'b1;
    end
    @(negedge clock);
    check_outputs();
  endtask

  task automatic idle(input logic wbr);
    cycle(1'b0, 5'd0, '0, '0, '0, 1'b1, 3'b000, 5'd0, 1'b0, 1'b0, wbr);
  endtask

  logic [VLEN-1:0] old_aa, res32, res8, res16, r_a, r_b, r_c;

  initial begin
    n_cmp = 0; n_mis = 0; m_count = 32'd0; m_illegal = 1'b0;
    reset_n = 1'b0; in_valid = 1'b0; in_vd_addr = 5'd0; in_result = '0;
    in_old_vd = '0; in_v0 = '0; in_vm = 1'b1; in_vsew = 3'b000;
    in_vl = 5'd0; in_vta = 1'b0; in_vma = 1'b0; wb_ready = 1'b0;
    old_aa = {16{8'hAA}};
    res32  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    res8   = 128'h0F0E0D0C0B0A09080706050403020100;
    res16  = 128'h77776666555544443333222211110000;

    #12;
    check_outputs();
    check_eq("rst_wb_data", wb_data, '0);
    check_eq("rst_wb_addr", VLEN'(wb_addr), '0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_outputs();

    // e32, vl=4, unmasked: full result one cycle after accept
    cycle(1'b1, 5'd1, res32, old_aa, '0, 1'b1, 3'b010, 5'd4, 1'b0, 1'b0, 1'b1);
    check_eq("e32_data", wb_data, res32);
    idle(1'b1);
    check_eq("e32_count", VLEN'(wb_count), VLEN'(32'd1));

    // e8, vl=10: tail undisturbed, then tail agnostic
    cycle(1'b1, 5'd2, res8, old_aa, '0, 1'b1, 3'b000, 5'd10, 1'b0, 1'b0, 1'b1);
    check_eq("e8_tu", wb_data, 128'hAAAAAAAAAAAA09080706050403020100);
    cycle(1'b1, 5'd2, res8, old_aa, '0, 1'b1, 3'b000, 5'd10, 1'b1, 1'b0, 1'b1);
    check_eq("e8_ta", wb_data, 128'hFFFFFFFFFFFF09080706050403020100);

    // e16, vl=8, masked by v0=0x00A5: undisturbed then agnostic
    cycle(1'b1, 5'd4, res16, old_aa, 128'h00A5, 1'b0, 3'b001, 5'd8, 1'b0, 1'b0, 1'b1);
    check_eq("e16_mu", wb_data, 128'h7777AAAA5555AAAAAAAA2222AAAA0000);
    cycle(1'b1, 5'd4, res16, old_aa, 128'h00A5, 1'b0, 3'b001, 5'd8, 1'b0, 1'b1, 1'b1);
    check_eq("e16_ma", wb_data, 128'h7777FFFF5555FFFFFFFF2222FFFF0000);
    idle(1'b1);

    // same-address hazard, full FIFO backpressure, in-order drain
    r_a = {4{32'hCAFE0001}}; r_b = {4{32'hBEEF0002}}; r_c = {4{32'h5A5A5A5A}};
    cycle(1'b1, 5'd3, r_a, old_aa, '0, 1'b1, 3'b010, 5'd4, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 5'd3, r_b, old_aa, '0, 1'b1, 3'b010, 5'd4, 1'b0, 1'b0, 1'b0);
    check_eq("full_in_ready", VLEN'(in_ready), '0);
    check_eq("full_pending", VLEN'(pending_mask), VLEN'(32'h8));
    cycle(1'b1, 5'd7, r_c, old_aa, '0, 1'b1, 3'b010, 5'd4, 1'b0, 1'b0, 1'b0);
    check_eq("third_rejected", VLEN'(pending_mask), VLEN'(32'h8));
    check_eq("head_first", wb_data, r_a);
    idle(1'b1);
    check_eq("head_second", wb_data, r_b);
    check_eq("one_left_pending", VLEN'(pending_mask), VLEN'(32'h8));
    idle(1'b1);
    check_eq("drained_pending", VLEN'(pending_mask), '0);

    // reserved vsew: pass-through and sticky flag; leave FIFO full
    cycle(1'b1, 5'd9, r_c, old_aa, '0, 1'b0, 3'b100, 5'd3, 1'b1, 1'b1, 1'b0);
    check_eq("rsv_illegal", VLEN'(illegal_sew), VLEN'(1'b1));
    check_eq("rsv_data", wb_data, r_c);
    cycle(1'b1, 5'd12, res8, old_aa, '0, 1'b1, 3'b000, 5'd0, 1'b1, 1'b0, 1'b0);

    // async reset with FIFO full: outputs clear without a clock edge
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_wb_valid", VLEN'(wb_valid), '0);
    check_eq("arst_wb_addr", VLEN'(wb_addr), '0);
    check_eq("arst_wb_data", wb_data, '0);
    check_eq("arst_pending", VLEN'(pending_mask), '0);
    check_eq("arst_illegal", VLEN'(illegal_sew), '0);
    check_eq("arst_count", VLEN'(wb_count), '0);
    check_eq("arst_in_ready", VLEN'(in_ready), VLEN'(1'b1));
    @(negedge clock);
    reset_n = 1'b1;
    q.delete(); m_count = 32'd0; m_illegal = 1'b0;
    @(negedge clock);
    check_outputs();

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [2:0] vs;
      vs = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(4, 7))
                                         : 3'($urandom_range(0, 3));
      cycle(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
            {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom},
            1'($urandom_range(0, 1)), vs, VL_W'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0));
    end
    for (int n = 0; n < 3; n++) idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
